// File: rtl/rf_wb_if.sv
// rf_wb_if -- bus bundle between the pipeline and the register-file /
// write-back block.
//
// Write side (master -> slave):
//   wdsel[2:0]   write-back source select
//   aluo, dmout, pc_4, cp0out [31:0]  write-back candidates
//   we           write request for this cycle
//   wa[4:0]      destination register
// Read side:
//   ra1, ra2 [4:0]  read addresses (master -> slave)
//   rd1, rd2 [31:0] read data, combinational (slave -> master)
//   haz1, haz2      read address hits a pending, not yet visible write
//   wb_pend         write-back register holds a valid write
//
// Handshake: there is no ready. A write is accepted unconditionally on every
// rising edge where we=1. It is captured into the write-back register on that
// edge and lands in the array on the next edge. Reads are combinational and
// always valid.
interface rf_wb_if;
  logic [2:0]  wdsel;
  logic [31:0] aluo;
  logic [31:0] dmout;
  logic [31:0] pc_4;
  logic [31:0] cp0out;
  logic        we;
  logic [4:0]  wa;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        haz1;
  logic        haz2;
  logic        wb_pend;

  modport master (
    output wdsel, aluo, dmout, pc_4, cp0out, we, wa, ra1, ra2,
    input  rd1, rd2, haz1, haz2, wb_pend
  );

  modport slave (
    input  wdsel, aluo, dmout, pc_4, cp0out, we, wa, ra1, ra2,
    output rd1, rd2, haz1, haz2, wb_pend
  );
endinterface

// File: rtl/rf_wb.sv
// rf_wb -- 32x32 register file with a one-stage write-back register.
//
// Ports:
//   clk    single clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    rf_wb_if.slave (write candidates, write request, read ports,
//          hazard flags, wb_pend)
//
// A write is captured into the write-back (WB) register on one edge and
// committed to the array on the next, so it becomes visible in the array two
// edges after the request.
//
// Optional feature: define RF_BYPASS_EN to forward the WB register to the
// read ports. Without it the read ports show only the array and haz1/haz2
// flag reads that would miss a pending write.
//
// No FSM in this block; the WB register state is visible through wb_pend.
module rf_wb (
  input  logic     clk,
  input  logic     rst_n,
  rf_wb_if.slave   bus
);

  logic [31:0] regs [0:31];
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_data;

  logic [31:0] sel_data;
  logic        sel_ok;

  // Source select. Codes 101-111 produce zero and suppress the write.
  always_comb begin
    sel_data = 32'h0;
    sel_ok   = 1'b1;
    case (bus.wdsel)
      3'b000:  sel_data = bus.aluo;
      3'b001:  sel_data = bus.dmout;
      3'b010:  sel_data = bus.pc_4;
      3'b011:  sel_data = 32'h1;
      3'b100:  sel_data = bus.cp0out;
      default: begin
        sel_data = 32'h0;
        sel_ok   = 1'b0;
      end
    endcase
  end

  // Stage 1: WB register. A write to r0 never becomes valid, so r0 is never
  // written and stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we   <= 1'b0;
      wb_wa   <= 5'd0;
      wb_data <= 32'h0;
    end else begin
      wb_we   <= bus.we & sel_ok & (bus.wa != 5'd0);
      wb_wa   <= bus.wa;
      wb_data <= sel_data;
    end
  end

  // Stage 2: array commit. On the same edge the WB register takes the newer
  // write, the array takes the older one, so back-to-back writes resolve to
  // the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (wb_we) begin
      regs[wb_wa] <= wb_data;
    end
  end

  logic hit1;
  logic hit2;

  assign hit1 = wb_we & (wb_wa == bus.ra1) & (bus.ra1 != 5'd0);
  assign hit2 = wb_we & (wb_wa == bus.ra2) & (bus.ra2 != 5'd0);

  logic [31:0] arr1;
  logic [31:0] arr2;

  always_comb begin
    arr1 = 32'h0;
    arr2 = 32'h0;
    if (bus.ra1 != 5'd0) arr1 = regs[bus.ra1];
    if (bus.ra2 != 5'd0) arr2 = regs[bus.ra2];
  end

`ifdef RF_BYPASS_EN
  assign bus.rd1  = hit1 ? wb_data : arr1;
  assign bus.rd2  = hit2 ? wb_data : arr2;
  assign bus.haz1 = 1'b0;
  assign bus.haz2 = 1'b0;
`else
  assign bus.rd1  = arr1;
  assign bus.rd2  = arr2;
  assign bus.haz1 = hit1;
  assign bus.haz2 = hit2;
`endif

  assign bus.wb_pend = wb_we;

endmodule
